host_cmd_link: RTL and testbench
================================

// Module: host_cmd_link
// PURPOSE
//  Serial host-side endpoint of the core's command/response handshake: receives 8N1 UART bytes on RX,
//  assembles 3-byte host commands into cmd[23:0] with a cmd_rdy/clr_cmd_rdy handshake, and serialises
//  core response bytes (resp_data/send_resp) onto TX, acknowledging with resp_sent. Sits between the
//  board UART pins and the command/config logic of the digital core.
// PARAMETERS
//  BAUD_DIV      2604  clk cycles per bit period (50 MHz / 19200 baud); must be >= 4
//  TIMEOUT_BITS  20    bit periods of RX-idle allowed between bytes of one command before the partial is dropped
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  RX           in   1   serial input from host, asynchronous, idle high
//  TX           out  1   serial output to host, idle high
//  cmd          out  24  assembled command {byte0,byte1,byte2}
//  cmd_rdy      out  1   cmd valid; held until clr_cmd_rdy
//  clr_cmd_rdy  in   1   core consumed cmd; 1-cycle pulse
//  resp_data    in   8   response byte, sampled when send_resp=1
//  send_resp    in   1   1-cycle request to transmit resp_data
//  resp_sent    out  1   1-cycle pulse when the stop bit of a response byte has finished
//  tx_busy      out  1   transmitter occupied; send_resp ignored while high
//  frm_err      out  1   1-cycle pulse: RX stop bit sampled low (byte discarded)
//  ovr_err      out  1   1-cycle pulse: RX byte completed while cmd_rdy=1 (byte discarded)
// BEHAVIOUR
//  Reset: TX=1, cmd=24'h0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0, ovr_err=0; RX sync flops=1;
//   all FSMs idle, counters 0. Reset mid-frame on either side aborts it with no pulse emitted.
//  RX byte engine: RX through 2-flop synchroniser. Start = synced RX low while idle. Sample start at
//   BAUD_DIV/2; if high, false start -> idle. Data sampled each BAUD_DIV thereafter, LSB first; stop
//   sampled at mid-bit 9. Stop=1 -> byte_vld 1 cycle; stop=0 -> frm_err, no byte_vld. Engine returns to
//   idle at stop mid-bit (re-arms for back-to-back bytes).
//  Assembly FSM: BYTE0 -> BYTE1 -> BYTE2 -> HOLD.
//   BYTE0: byte_vld -> cmd[23:16]<=byte, ->BYTE1.  BYTE1: -> cmd[15:8], ->BYTE2.
//   BYTE2: -> cmd[7:0], cmd_rdy<=1 next cycle, ->HOLD.
//   HOLD: cmd frozen; byte_vld -> ovr_err, byte dropped. clr_cmd_rdy -> cmd_rdy<=0, ->BYTE0.
//   clr_cmd_rdy in the same cycle as byte_vld in HOLD: clear wins, byte loaded as byte0, ->BYTE1, no ovr_err.
//   clr_cmd_rdy outside HOLD: ignored.
//  Timeout: in BYTE1/BYTE2, counter counts clk while RX engine idle; reset on each start detect.
//   At TIMEOUT_BITS*BAUD_DIV -> ->BYTE0, partial discarded (cmd bits unchanged, cmd_rdy stays 0).
//  frm_err does not advance or reset the assembly FSM.
//  TX FSM: IDLE, START, DATA, STOP. IDLE & send_resp -> latch resp_data, tx_busy=1, TX=0 next cycle.
//   Each bit held exactly BAUD_DIV cycles; data LSB first; stop=1. At end of stop period: ->IDLE,
//   tx_busy=0, resp_sent=1 for one cycle. Frame = 10*BAUD_DIV cycles from first TX low.
//   send_resp while tx_busy: ignored, not queued. send_resp in the resp_sent cycle: accepted.
//  RX and TX fully independent (full duplex).
//  Counter widths: $clog2(BAUD_DIV+1) for bit timers; $clog2(TIMEOUT_BITS*BAUD_DIV+1) for timeout.
// STRUCTURE
//  Shared package (host_link_pkg): asm_state_t {BYTE0,BYTE1,BYTE2,HOLD}, tx_state_t
//   {TX_IDLE,TX_START,TX_DATA,TX_STOP}, constants CMD_BYTES=3, FRAME_BITS=10.
//  One sub-module: uart_rx_byte (synchroniser, start detect, sampling, byte_vld/frm_err, rx_idle out).
//  Assembly FSM, timeout counter and TX FSM live in host_cmd_link.
// TESTING (BAUD_DIV=16, TIMEOUT_BITS=20 in bench)
//  Send 8'hA5,8'h01,8'h3C back-to-back -> cmd_rdy=1 with cmd=24'hA5013C; stays until clr_cmd_rdy; next cycle cmd_rdy=0.
//  While cmd_rdy=1 send 8'h77 -> ovr_err pulse, cmd still 24'hA5013C; then clr + 8'h77 same cycle -> byte0=8'h77 accepted.
//  Send 8'h12, idle 25 bit-times, send 8'h34,8'h56,8'h78 -> one cmd_rdy, cmd=24'h345678.
//  Byte 8'hFF with stop bit forced low -> frm_err pulse, FSM state unchanged, next 3 good bytes assemble.
//  send_resp with resp_data=8'hC3 -> TX=0,1,1,0,0,0,0,1,1,1 per 16 clk; resp_sent at cycle 160; send_resp at cycle 40 ignored.
//  Assert rst mid-RX-byte and mid-TX-byte -> TX=1 next cycle, no resp_sent/cmd_rdy, clean frames afterwards.

Source files
------------

// File: rtl/host_link_pkg.sv
// host_link_pkg: shared state encodings and framing constants for the host command link
package host_link_pkg;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, HOLD} asm_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  localparam int CMD_BYTES = 3;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchroniser, mid-bit sampling and framing check
module uart_rx_byte
  import host_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_vld,
  output logic       frm_err,
  output logic       rx_idle
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  logic rx_s1, rx_s2, busy, smp;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  assign smp = busy && cnt == (bit_idx == 4'd0 ? HALF : FULL);
  assign rx_idle = !busy;
  // synchronise RX, detect start, sample start/data/stop at bit centres
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      busy <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
      byte_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      byte_vld <= 1'b0;
      frm_err <= 1'b0;
      if (!busy) begin
        busy <= !rx_s2;
        cnt <= '0;
        bit_idx <= '0;
      end else if (!smp) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        bit_idx <= bit_idx + 1'b1;
        if (bit_idx == 4'd0) busy <= !rx_s2;
        else if (bit_idx == 4'(FRAME_BITS - 1)) begin
          busy <= 1'b0;
          byte_vld <= rx_s2;
          frm_err <= !rx_s2;
        end else data <= {rx_s2, data[7:1]};
      end
    end
  end
endmodule

// File: rtl/host_cmd_link.sv
// host_cmd_link: UART endpoint assembling 3-byte host commands and serialising response bytes
module host_cmd_link
  import host_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RX,
  output logic                     TX,
  output logic [8*CMD_BYTES-1:0]   cmd,
  output logic                     cmd_rdy,
  input  logic                     clr_cmd_rdy,
  input  logic [7:0]               resp_data,
  input  logic                     send_resp,
  output logic                     resp_sent,
  output logic                     tx_busy,
  output logic                     frm_err,
  output logic                     ovr_err
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_BITS * BAUD_DIV - 1);
  asm_state_t asm_q, asm_d;
  tx_state_t tx_q, tx_d;
  logic [7:0] rx_data, tx_sh;
  logic byte_vld, rx_idle, partial, timeout, tx_tick;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(RX),
    .data(rx_data),
    .byte_vld(byte_vld),
    .frm_err(frm_err),
    .rx_idle(rx_idle)
  );

  assign partial = asm_q == BYTE1 || asm_q == BYTE2;
  assign timeout = partial && rx_idle && to_cnt == TO_LIM;
  assign cmd_rdy = asm_q == HOLD;
  assign tx_tick = tx_cnt == FULL;
  assign tx_busy = tx_q != TX_IDLE;
  assign TX = tx_q == TX_START ? 1'b0 : tx_q == TX_DATA ? tx_sh[0] : 1'b1;

  // command assembly next state; a clear in HOLD takes priority over an incoming byte
  always_comb begin
    asm_d = asm_q;
    case (asm_q)
      BYTE0:   asm_d = byte_vld ? BYTE1 : BYTE0;
      BYTE1:   asm_d = byte_vld ? BYTE2 : timeout ? BYTE0 : BYTE1;
      BYTE2:   asm_d = byte_vld ? HOLD : timeout ? BYTE0 : BYTE2;
      default: asm_d = clr_cmd_rdy ? (byte_vld ? BYTE1 : BYTE0) : HOLD;
    endcase
  end

  // assembly state, command bytes, overrun flag and inter-byte idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= BYTE0;
      cmd <= '0;
      ovr_err <= 1'b0;
      to_cnt <= '0;
    end else begin
      asm_q <= asm_d;
      ovr_err <= asm_q == HOLD && byte_vld && !clr_cmd_rdy;
      to_cnt <= (partial && asm_d == asm_q && rx_idle) ? to_cnt + 1'b1 : '0;
      if (byte_vld && (asm_q == BYTE0 || (asm_q == HOLD && clr_cmd_rdy))) cmd[23:16] <= rx_data;
      if (byte_vld && asm_q == BYTE1) cmd[15:8] <= rx_data;
      if (byte_vld && asm_q == BYTE2) cmd[7:0] <= rx_data;
    end
  end

  // transmitter next state; every frame bit lasts one full bit period
  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      TX_IDLE:  tx_d = send_resp ? TX_START : TX_IDLE;
      TX_START: tx_d = tx_tick ? TX_DATA : TX_START;
      TX_DATA:  tx_d = (tx_tick && tx_bit == 3'd7) ? TX_STOP : TX_DATA;
      default:  tx_d = tx_tick ? TX_IDLE : TX_STOP;
    endcase
  end

  // transmitter state, bit timer, shift register and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      resp_sent <= 1'b0;
    end else begin
      tx_q <= tx_d;
      tx_cnt <= (tx_q == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      resp_sent <= tx_q == TX_STOP && tx_tick;
      if (tx_q == TX_IDLE && send_resp) tx_sh <= resp_data;
      if (tx_q == TX_DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_host_cmd_link.sv
// tb_host_cmd_link: directed self-checking bench for the host command link
module tb_host_cmd_link;
  localparam int BD = 16;
  logic clk = 1'b0, rst = 1'b1, RX = 1'b1, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic TX, cmd_rdy, resp_sent, tx_busy, frm_err, ovr_err;
  logic [23:0] cmd;
  logic [9:0] fr;
  logic rdy_prev = 1'b0;
  int checks = 0, failures = 0, ovr_n = 0, frm_n = 0, rdy_n = 0, sent_n = 0;

  always #5 clk = ~clk;

  host_cmd_link #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
    .clk(clk),
    .rst(rst),
    .RX(RX),
    .TX(TX),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data(resp_data),
    .send_resp(send_resp),
    .resp_sent(resp_sent),
    .tx_busy(tx_busy),
    .frm_err(frm_err),
    .ovr_err(ovr_err)
  );

  always @(posedge clk) begin
    if (ovr_err) ovr_n++;
    if (frm_err) frm_n++;
    if (resp_sent) sent_n++;
    if (cmd_rdy && !rdy_prev) rdy_n++;
    rdy_prev = cmd_rdy;
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task send_byte(input logic [7:0] b, input logic stop = 1'b1, input logic clr_on_vld = 1'b0);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) begin
        @(negedge clk);
        if (clr_on_vld) clr_cmd_rdy = dut.u_rx.byte_vld;
      end
    end
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task pulse_clr;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_rdy", cmd_rdy, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_sent", resp_sent, 0);
    check("rst_frm", frm_err, 0);
    check("rst_ovr", ovr_err, 0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h3C);
    repeat (2 * BD) @(negedge clk);
    check("cmd1_rdy", cmd_rdy, 1);
    check("cmd1", cmd, 24'hA5013C);
    check("cmd1_rises", rdy_n, 1);
    send_byte(8'h77);
    repeat (BD) @(negedge clk);
    check("ovr_pulse", ovr_n, 1);
    check("ovr_cmd_frozen", cmd, 24'hA5013C);
    check("ovr_rdy_held", cmd_rdy, 1);
    send_byte(8'h77, 1'b1, 1'b1);
    check("clr_vld_rdy", cmd_rdy, 0);
    check("clr_vld_no_ovr", ovr_n, 1);
    send_byte(8'h88);
    send_byte(8'h99);
    repeat (2 * BD) @(negedge clk);
    check("cmd2", cmd, 24'h778899);
    check("cmd2_rises", rdy_n, 2);
    pulse_clr();
    check("clr_next_cycle", cmd_rdy, 0);
    send_byte(8'h12);
    repeat (25 * BD) @(negedge clk);
    check("timeout_no_rdy", cmd_rdy, 0);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    repeat (2 * BD) @(negedge clk);
    check("cmd3", cmd, 24'h345678);
    check("cmd3_rises", rdy_n, 3);
    check("cmd3_no_ovr", ovr_n, 1);
    pulse_clr();
    send_byte(8'hDE);
    send_byte(8'hFF, 1'b0);
    repeat (BD) @(negedge clk);
    check("frm_pulse", frm_n, 1);
    check("frm_no_rdy", cmd_rdy, 0);
    send_byte(8'hAD);
    send_byte(8'hBE);
    repeat (2 * BD) @(negedge clk);
    check("cmd4", cmd, 24'hDEADBE);
    check("cmd4_rises", rdy_n, 4);
    pulse_clr();
    resp_data = 8'hC3;
    fr = {1'b1, 8'hC3, 1'b0};
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int c = 0; c <= 161; c++) begin
      if (c == 0) check("tx_busy_start", tx_busy, 1);
      if (c % BD == BD / 2 && c < 10 * BD) check($sformatf("tx_bit%0d", c / BD), TX, fr[c/BD]);
      if (c == 159) check("sent_early", resp_sent, 0);
      if (c == 160) check("sent_160", resp_sent, 1);
      if (c == 160) check("busy_end", tx_busy, 0);
      if (c == 161) check("sent_one_cycle", resp_sent, 0);
      if (c == 40) begin
        resp_data = 8'h00;
        send_resp = 1'b1;
      end
      if (c == 41) send_resp = 1'b0;
      @(negedge clk);
    end
    check("sent_count1", sent_n, 1);
    check("busy_ignored", tx_busy, 0);
    resp_data = 8'h55;
    send_resp = 1'b1;
    RX = 1'b0;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", TX, 1);
    check("midrst_busy", tx_busy, 0);
    rst = 1'b0;
    RX = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_sent", sent_n, 1);
    check("midrst_no_frm", frm_n, 1);
    check("midrst_no_rdy", rdy_n, 4);
    check("midrst_cmd", cmd, 0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    repeat (2 * BD) @(negedge clk);
    check("cmd5", cmd, 24'hABCDEF);
    check("cmd5_rdy", cmd_rdy, 1);
    resp_data = 8'h5A;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (10 * BD + 10) @(negedge clk);
    check("sent_count2", sent_n, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
